// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and helpers for the folded symmetric FIR.
// FIR_SAT_EN selects saturation of the shifted accumulator; otherwise it wraps.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

    // Working width for the output reduction; wide enough for any sane AW.
    localparam int RED_W = 128;

    function automatic int fir_acc_width(input int dw, input int cw, input int n_taps);
        return dw + cw + 1 + $clog2(n_taps / 2);
    endfunction

    function automatic logic signed [RED_W-1:0] fir_reduce(input logic signed [RED_W-1:0] v,
                                                         input int dw);
`ifdef FIR_SAT_EN
        logic signed [RED_W-1:0] one;
        logic signed [RED_W-1:0] hi;
        logic signed [RED_W-1:0] lo;
        one = 1;
        hi  = (one <<< (dw - 1)) - one;
        lo  = ~hi;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
`else
        int sh;
        sh = RED_W - dw;
        // Keep the low dw bits, sign-extended back to full width.
        return (v <<< sh) >>> sh;
`endif
    endfunction

endpackage

// File: rtl/fir_preadd_mac.sv
// rtl/fir_preadd_mac.sv - symmetric pre-add, multiply and registered accumulator.
module fir_preadd_mac #(
    parameter int DW = 32,
    parameter int CW = 16,
    parameter int AW = 55
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] d_near,
    input  logic signed [DW-1:0] d_far,
    input  logic signed [CW-1:0] coef,
    output logic signed [AW-1:0] acc_next
);

    localparam int PW = DW + CW + 1;

    logic signed [DW:0]   preadd;
    logic signed [PW-1:0] pre_x;
    logic signed [PW-1:0] coef_x;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc;

    assign preadd   = {d_near[DW-1], d_near} + {d_far[DW-1], d_far};
    assign pre_x    = PW'(preadd);
    assign coef_x   = PW'(coef);
    assign prod     = pre_x * coef_x;
    assign acc_next = acc + AW'(prod);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/fir_symm_folded.sv
// rtl/fir_symm_folded.sv - folded symmetric FIR: one pre-add/MAC shared over N_TAPS/2 taps.
// Output reduction follows FIR_SAT_EN (saturate) or its absence (wrap).
module fir_symm_folded
    import fir_pkg::*;
#(
    parameter int N_TAPS = 100,
    parameter int DW     = 32,
    parameter int CW     = 16,
    parameter int SHIFT  = 15,
    parameter int AW     = fir_acc_width(DW, CW, N_TAPS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic signed [DW-1:0]            x_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [DW-1:0]            y_out,
    input  logic                            coef_we,
    input  logic [$clog2(N_TAPS/2)-1:0]     coef_addr,
    input  logic signed [CW-1:0]            coef_data,
    output logic                            coef_ready
);

    localparam int HALF = N_TAPS / 2;
    localparam int KW   = $clog2(HALF);
    localparam int DIW  = KW + 1;

    fir_state_t state;
    fir_state_t state_nxt;

    logic signed [DW-1:0] d [N_TAPS];
    logic signed [CW-1:0] h [HALF];
    logic [KW-1:0]        k;
    logic [DIW-1:0]       k_near;
    logic [DIW-1:0]       k_far;
    logic                 accept;
    logic                 mac_en;
    logic                 last_tap;
    logic signed [AW-1:0] acc_next;
    logic signed [AW-1:0] acc_shr;
    logic signed [DW-1:0] y_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        coef_ready = 1'b0;
        accept     = 1'b0;
        mac_en     = 1'b0;
        case (state)
            IDLE: begin
                in_ready   = 1'b1;
                coef_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (last_tap) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign last_tap = (k == KW'(HALF - 1));
    assign k_near   = {1'b0, k};
    assign k_far    = DIW'(N_TAPS - 1) - k_near;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_TAPS; i++) begin
                d[i] <= '0;
            end
        end else if (accept) begin
            d[0] <= x_in;
            for (int i = 1; i < N_TAPS; i++) begin
                d[i] <= d[i-1];
            end
        end
    end

    // Writes land even on the accept edge: the MAC first reads h on the following cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HALF; i++) begin
                h[i] <= '0;
            end
        end else if (coef_we && coef_ready && (int'(coef_addr) < HALF)) begin
            h[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k <= '0;
        end else if (accept) begin
            k <= '0;
        end else if (state == MAC) begin
            k <= k + 1'b1;
        end
    end

    fir_preadd_mac #(
        .DW (DW),
        .CW (CW),
        .AW (AW)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clr      (accept),
        .en       (mac_en),
        .d_near   (d[k_near]),
        .d_far    (d[k_far]),
        .coef     (h[k]),
        .acc_next (acc_next)
    );

    // The last term is folded in via acc_next so y_out is ready on the final MAC edge.
    assign acc_shr = acc_next >>> SHIFT;
    assign y_nxt   = DW'(fir_reduce(RED_W'(acc_shr), DW));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_out <= '0;
        end else if ((state == MAC) && last_tap) begin
            y_out <= y_nxt;
        end
    end

endmodule

// File: tb/tb_fir_symm_folded.sv
// tb/tb_fir_symm_folded.sv - self-checking bench for fir_symm_folded against a direct-form model.
`timescale 1ns/1ps
module tb_fir_symm_folded;

    localparam int N     = 8;
    localparam int DW    = 12;
    localparam int CW    = 8;
    localparam int SHIFT = 2;
    localparam int HALF  = N / 2;
    localparam int KW    = $clog2(HALF);

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] x_in = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] y_out;
    logic                 coef_we = 1'b0;
    logic [KW-1:0]        coef_addr = '0;
    logic signed [CW-1:0] coef_data = '0;
    logic                 coef_ready;

    int     n_vec = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     acc_cyc = 0;
    longint hist [N];
    longint hcoef [HALF];
    longint expq [$];
    longint last_y = 0;

    fir_symm_folded #(
        .N_TAPS (N),
        .DW     (DW),
        .CW     (CW),
        .SHIFT  (SHIFT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x_in       (x_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y_out      (y_out),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .coef_ready (coef_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Direct-form convolution with the full symmetric impulse response.
    function automatic longint model_y();
        longint s;
        longint lim;
        s   = 0;
        lim = longint'(1) << (DW - 1);
        for (int i = 0; i < N; i++) begin
            s += hcoef[(i < HALF) ? i : N - 1 - i] * hist[i];
        end
        s = s >>> SHIFT;
`ifdef FIR_SAT_EN
        if (s > lim - 1) s = lim - 1;
        else if (s < -lim) s = -lim;
`else
        s = s % (2 * lim);
        if (s < 0) s += 2 * lim;
        if (s >= lim) s -= 2 * lim;
`endif
        return s;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            check("ready_valid_exclusive", longint'(in_ready & out_valid), 0);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    last_y = longint'(y_out);
                    check("y_out", longint'(y_out), expq.pop_front());
                end
            end
        end
    end

    task automatic accept(input longint x, input bit cw, input int ca, input longint cd);
        int t;
        t = 0;
        in_valid  = 1'b1;
        x_in      = DW'(x);
        coef_we   = cw;
        coef_addr = KW'(ca);
        coef_data = CW'(cd);
        @(negedge clk);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = x;
        if (cw && ca < HALF) hcoef[ca] = cd;
        expq.push_back(model_y());
        #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic complete(input int hold);
        int     t;
        longint y0;
        t = 0;
        while (!out_valid && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("latency", longint'(cyc - acc_cyc), HALF);
        y0 = longint'(y_out);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_y_out", longint'(y_out), y0);
            check("hold_out_valid", longint'(out_valid), 1);
            check("hold_in_ready", longint'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic wr(input int a, input longint v);
        coef_we   = 1'b1;
        coef_addr = KW'(a);
        coef_data = CW'(v);
        @(negedge clk);
        check("coef_ready_idle", longint'(coef_ready), 1);
        @(posedge clk);
        hcoef[a] = v;
        #1;
        coef_we = 1'b0;
    endtask

    initial begin
        longint sym [8];
        longint sat_lit;
        longint x;
        sym = '{1, 2, 3, 4, 4, 3, 2, 1};
`ifdef FIR_SAT_EN
        sat_lit = 2047;
`else
        sat_lit = -254;
`endif
        for (int i = 0; i < N; i++) hist[i] = 0;
        for (int i = 0; i < HALF; i++) hcoef[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", longint'(in_ready), 1);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_y_out", longint'(y_out), 0);
        check("reset_coef_ready", longint'(coef_ready), 1);
        reset = 1'b0;

        // Full symmetric response to a unit impulse
        wr(0, 4); wr(1, 8); wr(2, 12); wr(3, 16);
        for (int i = 0; i < 8; i++) begin
            accept((i == 0) ? 1 : 0, 1'b0, 0, 0);
            complete(0);
            check("symmetric_literal", last_y, sym[i]);
        end

        // Arithmetic shift floors toward minus infinity
        wr(0, 1); wr(1, 0); wr(2, 0); wr(3, 0);
        accept(-1, 1'b0, 0, 0);
        complete(0);
        check("floor_literal", last_y, -1);

        // Saturate / wrap at full-scale input
        for (int a = 0; a < HALF; a++) wr(a, 127);
        for (int i = 0; i < 8; i++) begin
            accept(2047, 1'b0, 0, 0);
            complete(0);
        end
        check("overflow_literal", last_y, sat_lit);

        // Backpressure with a stray sample presented in OUT
        accept(300, 1'b0, 0, 0);
        in_valid = 1'b1;
        x_in     = 12'sd77;
        complete(10);
        in_valid = 1'b0;
        check("no_stray_accept", longint'(in_ready), 1);

        // Coefficient write attempted mid-MAC is dropped
        wr(0, 4); wr(1, 8); wr(2, 12); wr(3, 16);
        for (int i = 0; i < 8; i++) begin
            accept(0, 1'b0, 0, 0);
            complete(0);
        end
        accept(1, 1'b0, 0, 0);
        coef_we   = 1'b1;
        coef_addr = '0;
        coef_data = 8'sd9;
        @(negedge clk);
        check("coef_ready_mac", longint'(coef_ready), 0);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        complete(0);
        check("midmac_first_literal", last_y, 1);
        for (int i = 0; i < 7; i++) begin
            accept(0, 1'b0, 0, 0);
            complete(0);
        end
        check("midmac_readback_literal", last_y, 1);

        // Reset in the middle of MAC
        accept(5, 1'b0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_out_valid", longint'(out_valid), 0);
        check("abort_in_ready", longint'(in_ready), 1);
        check("abort_y_out", longint'(y_out), 0);
        for (int i = 0; i < N; i++) hist[i] = 0;
        for (int i = 0; i < HALF; i++) hcoef[i] = 0;
        expq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        accept(1, 1'b0, 0, 0);
        complete(0);
        check("post_reset_literal", last_y, 0);

        // Randomized traffic with same-edge coefficient updates
        for (int a = 0; a < HALF; a++) wr(a, longint'($urandom_range(0, 255)) - 128);
        for (int i = 0; i < 60; i++) begin
            x = longint'($urandom_range(0, 4095)) - 2048;
            if ($urandom_range(0, 1) == 0) x = x >>> 4;
            accept(x, ($urandom_range(0, 3) == 0), int'($urandom_range(0, HALF - 1)),
                   longint'($urandom_range(0, 255)) - 128);
            complete(int'($urandom_range(0, 4)));
        end
        check("queue_drained", longint'(expq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
